// File: rtl/blake3_job_driver.sv
// blake3_job_driver
// Sequencer between a mining-job source and a single-block BLAKE3 hash
// pipeline. Each job supplies a chaining value, a message block, a target and
// a nonce range. For every nonce the driver patches the nonce into one message
// word, starts the pipeline, waits for its digest and compares that digest
// with the target. It reports the first winning nonce, range exhaustion or a
// pipeline timeout on a ready/valid result port.
//
// Ports
//   Clk, Rstn_I              clock, asynchronous active-low reset
//   Job_*                    job offer (ready/valid), captured in IDLE
//   Abort_I                  cancel the running job (ignored in IDLE/REPORT)
//   Hash_Strt_O ... Hash_*_O one-cycle start plus operands to the pipeline
//   Hash_Vld_I, Hash_H_I     pipeline result pulse and digest H0-H7
//   Res_*                    result (ready/valid): found, error, nonce, digest
module blake3_job_driver #(
    parameter int NONCE_WORD = 0,
    parameter int TIMEOUT    = 128
) (
    input  logic              Clk,
    input  logic              Rstn_I,
    input  logic              Job_Vld_I,
    output logic              Job_Rdy_O,
    input  logic [7:0][31:0]  Job_H_I,
    input  logic [15:0][31:0] Job_Msg_I,
    input  logic [31:0]       Job_BL_I,
    input  logic [255:0]      Job_Target_I,
    input  logic [31:0]       Job_NonceStart_I,
    input  logic [31:0]       Job_NonceCnt_I,
    input  logic              Abort_I,
    output logic              Hash_Strt_O,
    output logic [31:0]       Hash_BL_O,
    output logic              Hash_CS_O,
    output logic              Hash_CE_O,
    output logic              Hash_Root_O,
    output logic [7:0][31:0]  Hash_H_O,
    output logic [15:0][31:0] Hash_Msg_O,
    input  logic              Hash_Vld_I,
    input  logic [7:0][31:0]  Hash_H_I,
    output logic              Res_Vld_O,
    input  logic              Res_Rdy_I,
    output logic              Res_Found_O,
    output logic              Res_Err_O,
    output logic [31:0]       Res_Nonce_O,
    output logic [255:0]      Res_Hash_O
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    state_t            state_r;
    logic [31:0]       nonce_r;
    logic [31:0]       remaining_r;
    logic [15:0][31:0] msg_r;
    logic [255:0]      target_r;
    logic [255:0]      digest_r;
    logic [TMO_W-1:0]  tmo_r;

    logic [31:0]       next_nonce_s;
    logic              hit_s;

    // Replace the nonce word of a message block, leaving the rest untouched.
    function automatic logic [15:0][31:0] patch_msg(input logic [15:0][31:0] m,
                                                    input logic [31:0] n);
        logic [15:0][31:0] r;
        r             = m;
        r[NONCE_WORD] = n;
        return r;
    endfunction

    // Next nonce (wraps mod 2^32) and the unsigned digest-vs-target test.
    always_comb begin
        next_nonce_s = nonce_r + 32'd1;
        hit_s        = (digest_r <= target_r);
    end

    // Job sequencer: state, job registers and every registered output.
    always_ff @(posedge Clk or negedge Rstn_I) begin
        if (!Rstn_I) begin
            state_r     <= ST_IDLE;
            nonce_r     <= 32'd0;
            remaining_r <= 32'd0;
            msg_r       <= '0;
            target_r    <= 256'd0;
            digest_r    <= 256'd0;
            tmo_r       <= '0;
            Job_Rdy_O   <= 1'b1;
            Hash_Strt_O <= 1'b0;
            Hash_BL_O   <= 32'd0;
            Hash_CS_O   <= 1'b0;
            Hash_CE_O   <= 1'b0;
            Hash_Root_O <= 1'b0;
            Hash_H_O    <= '0;
            Hash_Msg_O  <= '0;
            Res_Vld_O   <= 1'b0;
            Res_Found_O <= 1'b0;
            Res_Err_O   <= 1'b0;
            Res_Nonce_O <= 32'd0;
            Res_Hash_O  <= 256'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    Hash_Strt_O <= 1'b0;
                    if (Job_Vld_I) begin
                        Job_Rdy_O   <= 1'b0;
                        Hash_H_O    <= Job_H_I;
                        Hash_BL_O   <= Job_BL_I;
                        Hash_CS_O   <= 1'b1;
                        Hash_CE_O   <= 1'b1;
                        Hash_Root_O <= 1'b1;
                        msg_r       <= Job_Msg_I;
                        target_r    <= Job_Target_I;
                        nonce_r     <= Job_NonceStart_I;
                        remaining_r <= Job_NonceCnt_I;
                        if (Job_NonceCnt_I == 32'd0) begin
                            // Empty range: report straight away, nothing hashed.
                            state_r     <= ST_REPORT;
                            Res_Vld_O   <= 1'b1;
                            Res_Found_O <= 1'b0;
                            Res_Err_O   <= 1'b0;
                            Res_Nonce_O <= Job_NonceStart_I;
                            Res_Hash_O  <= 256'd0;
                        end else begin
                            state_r     <= ST_ISSUE;
                            Hash_Strt_O <= 1'b1;
                            Hash_Msg_O  <= patch_msg(Job_Msg_I, Job_NonceStart_I);
                        end
                    end else begin
                        Job_Rdy_O <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    Hash_Strt_O <= 1'b0;
                    tmo_r       <= '0;
                    if (Abort_I) begin
                        state_r     <= ST_IDLE;
                        Job_Rdy_O   <= 1'b1;
                        Hash_CS_O   <= 1'b0;
                        Hash_CE_O   <= 1'b0;
                        Hash_Root_O <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (Abort_I) begin
                        state_r     <= ST_IDLE;
                        Job_Rdy_O   <= 1'b1;
                        Hash_CS_O   <= 1'b0;
                        Hash_CE_O   <= 1'b0;
                        Hash_Root_O <= 1'b0;
                    end else if (Hash_Vld_I) begin
                        // Valid wins over a timeout expiring in the same cycle.
                        digest_r <= Hash_H_I;
                        state_r  <= ST_CHECK;
                    end else if (tmo_r == TMO_LAST) begin
                        state_r     <= ST_REPORT;
                        Res_Vld_O   <= 1'b1;
                        Res_Found_O <= 1'b0;
                        Res_Err_O   <= 1'b1;
                        Res_Nonce_O <= nonce_r;
                        Res_Hash_O  <= 256'd0;
                    end else begin
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                ST_CHECK: begin
                    if (Abort_I) begin
                        state_r     <= ST_IDLE;
                        Job_Rdy_O   <= 1'b1;
                        Hash_CS_O   <= 1'b0;
                        Hash_CE_O   <= 1'b0;
                        Hash_Root_O <= 1'b0;
                    end else if (hit_s || (remaining_r == 32'd1)) begin
                        state_r     <= ST_REPORT;
                        remaining_r <= remaining_r - 32'd1;
                        Res_Vld_O   <= 1'b1;
                        Res_Found_O <= hit_s;
                        Res_Err_O   <= 1'b0;
                        Res_Nonce_O <= nonce_r;
                        Res_Hash_O  <= digest_r;
                    end else begin
                        state_r     <= ST_ISSUE;
                        remaining_r <= remaining_r - 32'd1;
                        nonce_r     <= next_nonce_s;
                        Hash_Strt_O <= 1'b1;
                        Hash_Msg_O  <= patch_msg(msg_r, next_nonce_s);
                    end
                end
                ST_REPORT: begin
                    if (Res_Rdy_I) begin
                        state_r     <= ST_IDLE;
                        Job_Rdy_O   <= 1'b1;
                        Res_Vld_O   <= 1'b0;
                        Res_Found_O <= 1'b0;
                        Res_Err_O   <= 1'b0;
                        Hash_CS_O   <= 1'b0;
                        Hash_CE_O   <= 1'b0;
                        Hash_Root_O <= 1'b0;
                    end else begin
                        state_r <= ST_REPORT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    Job_Rdy_O   <= 1'b1;
                    Hash_Strt_O <= 1'b0;
                    Res_Vld_O   <= 1'b0;
                end
            endcase
        end
    end

endmodule
